// File: rtl/shift_div16.sv
// -----------------------------------------------------------------------------
// shift_div16
//
// Sequential unsigned divider: 16-bit dividend by a B_WIDTH-bit divisor using
// restoring shift-subtract division, one quotient bit per clock, MSB first.
// All state changes on the falling edge of clk.
//
// Timing of one request (edges counted from acceptance E0):
//   E0       start accepted in IDLE, operands latched, busy rises
//   E1..E16  one iteration per edge; results published at E16, busy falls,
//            done rises
//   E17      done falls, back to IDLE; a new start is accepted at E18
//   b == 0   E0 goes straight to DONE: quotient=FFFF, remainder=0,
//            div_by_zero=1, busy never rises
//
// Handshake: start is a level request sampled only while in IDLE. Asserting
// it in IDLE is the "valid" and being in IDLE is the "ready"; the request is
// taken on the falling edge where both hold and div_rst is low. start is
// ignored in RUN and DONE, so a start held high re-triggers once per return
// to IDLE.
//
// Ports
//   clk          clock, falling-edge active
//   div_rst      synchronous active-high reset, has priority over start
//   start        request a new division
//   a            dividend (16 bits, unsigned)
//   b            divisor (B_WIDTH bits, unsigned)
//   busy         high while iterating
//   done         one-cycle pulse when results become valid
//   div_by_zero  last accepted request had b == 0
//   quotient     a / b, held until the next accepted start or reset
//   remainder    a mod b, held until the next accepted start or reset
//   state_dbg    current FSM state (0 IDLE, 1 RUN, 2 DONE) for observation
// -----------------------------------------------------------------------------
module shift_div16 #(
    parameter int B_WIDTH = 8
) (
    input  logic               clk,
    input  logic               div_rst,
    input  logic               start,
    input  logic [15:0]        a,
    input  logic [B_WIDTH-1:0] b,
    output logic               busy,
    output logic               done,
    output logic               div_by_zero,
    output logic [15:0]        quotient,
    output logic [B_WIDTH-1:0] remainder,
    output logic [1:0]         state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;

    // Operands captured at acceptance so input changes mid-operation are harmless.
    logic [15:0]        a_q;
    logic [B_WIDTH-1:0] b_q;

    // Partial remainder carries one extra bit: after the shift it can reach
    // 2*b-1, which does not fit in B_WIDTH bits.
    logic [B_WIDTH:0]   partial;

    // Quotient bits accumulate here and are only copied to the output at E16,
    // so the visible quotient keeps its previous value throughout RUN.
    logic [15:0]        quo_work;

    // Counts completed iterations, 0..15 while in RUN.
    logic [4:0]         iter;

    // Combinational single-iteration datapath.
    logic [3:0]         bit_idx;
    logic [B_WIDTH:0]   trial;
    logic               fits;
    logic [B_WIDTH:0]   partial_nxt;
    logic [15:0]        quo_nxt;

    always_comb begin
        bit_idx     = 4'd15 - iter[3:0];
        trial       = {partial[B_WIDTH-1:0], a_q[bit_idx]};
        fits        = (trial >= {1'b0, b_q});
        partial_nxt = trial;
        if (fits) begin
            partial_nxt = trial - {1'b0, b_q};
        end
        quo_nxt = {quo_work[14:0], fits};
    end

    assign state_dbg = state;

    always_ff @(negedge clk) begin
        if (div_rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            a_q         <= '0;
            b_q         <= '0;
            partial     <= '0;
            quo_work    <= '0;
            iter        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        a_q      <= a;
                        b_q      <= b;
                        partial  <= '0;
                        quo_work <= '0;
                        iter     <= '0;
                        if (b == '0) begin
                            // No iterations: publish the saturated result now.
                            state       <= DONE;
                            done        <= 1'b1;
                            div_by_zero <= 1'b1;
                            quotient    <= 16'hFFFF;
                            remainder   <= '0;
                        end else begin
                            state       <= RUN;
                            busy        <= 1'b1;
                            div_by_zero <= 1'b0;
                        end
                    end
                end

                RUN: begin
                    partial  <= partial_nxt;
                    quo_work <= quo_nxt;
                    iter     <= iter + 5'd1;
                    if (iter == 5'd15) begin
                        // 16th iteration: results become visible with done.
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= quo_nxt;
                        remainder <= partial_nxt[B_WIDTH-1:0];
                    end
                end

                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_div16.sv
// -----------------------------------------------------------------------------
// tb_shift_div16
//
// Directed bench for shift_div16 (B_WIDTH = 8). Inputs are driven and outputs
// sampled 1 time unit after each falling edge, half a period away from the
// next active edge. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_shift_div16;

    localparam int BW = 8;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic          clk;
    logic          div_rst;
    logic          start;
    logic [15:0]   a;
    logic [BW-1:0] b;
    logic          busy;
    logic          done;
    logic          div_by_zero;
    logic [15:0]   quotient;
    logic [BW-1:0] remainder;
    logic [1:0]    state_dbg;

    int checks;
    int errors;

    shift_div16 #(.B_WIDTH(BW)) dut (
        .clk         (clk),
        .div_rst     (div_rst),
        .start       (start),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .quotient    (quotient),
        .remainder   (remainder),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // One complete request through to IDLE, checking timing and results.
    task automatic run_op(input string tag, input logic [15:0] av, input logic [BW-1:0] bv,
                          input logic [15:0] eq, input logic [BW-1:0] er, input logic edz);
        int edges;
        int busy_cycles;
        logic [15:0] prev_q;
        prev_q = quotient;
        a      = av;
        b      = bv;
        start  = 1'b1;
        step();                      // E0
        start  = 1'b0;
        a      = ~av;                // operands must already be latched
        b      = ~bv;
        edges       = 1;
        busy_cycles = 0;
        if (bv != '0) check({tag, "_q_held"}, quotient, prev_q);
        while (!done && edges < 40) begin
            if (busy) busy_cycles++;
            step();
            edges++;
        end
        check({tag, "_done_edge"}, edges, (bv == '0) ? 1 : 17);
        check({tag, "_busy_cycles"}, busy_cycles, (bv == '0) ? 0 : 16);
        check({tag, "_quotient"}, quotient, eq);
        check({tag, "_remainder"}, remainder, er);
        check({tag, "_dz"}, div_by_zero, edz);
        check({tag, "_busy_at_done"}, busy, 0);
        check({tag, "_state_done"}, state_dbg, ST_DONE);
        step();                      // E17 (or E1 for b==0)
        check({tag, "_done_fall"}, done, 0);
        check({tag, "_state_idle"}, state_dbg, ST_IDLE);
        check({tag, "_q_hold"}, quotient, eq);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int edges;
        int saw_done;

        checks  = 0;
        errors  = 0;
        div_rst = 1'b1;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        repeat (3) step();
        div_rst = 1'b0;
        step();

        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dz", div_by_zero, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_state", state_dbg, ST_IDLE);

        // Basic cases, b > a, divide by zero and recovery.
        run_op("d1000_7", 16'd1000, 8'd7, 16'd142, 8'd6, 1'b0);
        run_op("d65535_255", 16'd65535, 8'd255, 16'd257, 8'd0, 1'b0);
        run_op("d5_9", 16'd5, 8'd9, 16'd0, 8'd5, 1'b0);
        run_op("d1234_0", 16'd1234, 8'd0, 16'hFFFF, 8'd0, 1'b1);
        run_op("d10_3", 16'd10, 8'd3, 16'd3, 8'd1, 1'b0);
        run_op("d1_1", 16'd1, 8'd1, 16'd1, 8'd0, 1'b0);

        // Start re-pulsed mid-run with different operands is ignored.
        a = 16'd1000; b = 8'd7; start = 1'b1;
        step();                      // E0
        start = 1'b0;
        repeat (4) step();           // E1..E4
        a = 16'd9; b = 8'd1; start = 1'b1;
        step();                      // E5
        start = 1'b0;
        check("repulse_state_run", state_dbg, ST_RUN);
        edges = 6;
        while (!done && edges < 40) begin
            step();
            edges++;
        end
        check("repulse_done_edge", edges, 17);
        check("repulse_quotient", quotient, 142);
        check("repulse_remainder", remainder, 6);
        step();

        // Reset mid-run: no done pulse, everything zeroed.
        a = 16'd1000; b = 8'd7; start = 1'b1;
        step();                      // E0
        start = 1'b0;
        repeat (7) step();           // E1..E7
        div_rst = 1'b1;
        step();                      // E8
        div_rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_quotient", quotient, 0);
        check("abort_remainder", remainder, 0);
        check("abort_state", state_dbg, ST_IDLE);
        saw_done = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done) saw_done = 1;
        end
        check("abort_no_done", saw_done, 0);
        run_op("d100_10", 16'd100, 8'd10, 16'd10, 8'd0, 1'b0);

        // Reset beats start on the same edge.
        a = 16'd50; b = 8'd5; start = 1'b1; div_rst = 1'b1;
        step();
        start = 1'b0; div_rst = 1'b0;
        check("rst_prio_state", state_dbg, ST_IDLE);
        check("rst_prio_busy", busy, 0);
        check("rst_prio_quotient", quotient, 0);
        step();
        check("rst_prio_still_idle", state_dbg, ST_IDLE);

        // Back-to-back with start held high: done pulses 18 edges apart.
        a = 16'd1000; b = 8'd7; start = 1'b1;
        step();                      // E0
        edges = 1;
        while (!done && edges < 40) begin
            step();
            edges++;
        end
        check("b2b_first_edge", edges, 17);
        check("b2b_first_quotient", quotient, 142);
        check("b2b_first_remainder", remainder, 6);
        a = 16'd200; b = 8'd3;
        step();                      // E17, start ignored in DONE
        edges = 1;
        check("b2b_gap_idle", state_dbg, ST_IDLE);
        while (!done && edges < 40) begin
            step();
            edges++;
        end
        start = 1'b0;
        check("b2b_period", edges, 18);
        check("b2b_second_quotient", quotient, 66);
        check("b2b_second_remainder", remainder, 2);
        step();
        check("b2b_end_idle", state_dbg, ST_IDLE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_div16.md
SHIFT_DIV16 -- requirements
Module: shift_div16

Interface
REQ-001 SHALL have parameter B_WIDTH, default 8, divisor width in bits; legal range 1..16.
REQ-002 SHALL have port clk  input  1  clock; all state updates on falling edge of clk.
REQ-003 SHALL have port div_rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port start  input  1  request a new division; sampled on falling edge.
REQ-005 SHALL have port a  input  16  dividend, unsigned.
REQ-006 SHALL have port b  input  B_WIDTH  divisor, unsigned.
REQ-007 SHALL have port busy  output  1  high while the division is iterating.
REQ-008 SHALL have port done  output  1  one-cycle pulse when results become valid.
REQ-009 SHALL have port div_by_zero  output  1  high when the last accepted request had b==0.
REQ-010 SHALL have port quotient  output  16  result a/b.
REQ-011 SHALL have port remainder  output  B_WIDTH  result a mod b.

Function
REQ-012 SHALL implement the FSM states IDLE, RUN and DONE, with the following transitions:
- IDLE -> RUN on start with b!=0.
- IDLE -> DONE on start with b==0.
- RUN -> DONE after the 16th iteration.
- DONE -> IDLE unconditionally.
REQ-013 SHALL latch a and b on the accepting edge (E0), so later changes on a or b do not affect the operation in progress.
REQ-014 SHALL perform restoring shift-subtract division, producing one quotient bit per RUN edge, MSB first.
- Each iteration: partial = {partial, next dividend bit}; if partial >= divisor, subtract the divisor and set the quotient bit to 1, else set it to 0.
REQ-015 SHALL hold the partial remainder in B_WIDTH+1 bits internally so the compare/subtract never overflows.
REQ-016 SHALL use a 5-bit iteration counter; RUN occupies exactly edges E1..E16.
REQ-017 SHALL drive busy=1 after E0 through E15 and busy=0 after E16.
REQ-018 SHALL drive done=1 only in the cycle after E16, i.e. in DONE state, and done=0 again after E17.
REQ-019 SHALL make quotient and remainder valid when done rises and hold them until the next accepted start or div_rst.
REQ-020 SHALL keep quotient and remainder at their previous values during RUN, and update them only at E16.
REQ-021 SHALL ignore start while in RUN or DONE, with no restart and no effect on the result.
REQ-022 SHALL accept start asserted in the IDLE cycle immediately after DONE, giving back-to-back operation with a period of 18 edges.
REQ-023 SHALL handle b==0 at E0 as follows:
- go directly to DONE with no iterations;
- quotient=16'hFFFF, remainder=0, div_by_zero=1;
- done=1 after E0, busy stays 0.
REQ-024 SHALL clear div_by_zero on the next accepted start with b!=0.
REQ-025 SHALL produce, for b > a, quotient=0 and remainder=a[B_WIDTH-1:0].
REQ-026 SHALL hold start level-insensitive beyond acceptance, so a start held high re-triggers only on return to IDLE.

Reset
REQ-027 SHALL, on div_rst=1 at a falling edge, force state IDLE with busy=0, done=0, div_by_zero=0, quotient=0, remainder=0, iteration counter=0 and latched operands=0.
REQ-028 SHALL give div_rst priority over start: when both are high on the same edge, reset wins and the request is dropped.
REQ-029 SHALL abort an operation on div_rst during RUN, with no done pulse and outputs zeroed per REQ-027.

Verification
REQ-030 SHALL cover a=1000, b=7 -> done one cycle after E16 with quotient=142, remainder=6, div_by_zero=0, and busy high for exactly 16 cycles.
REQ-031 SHALL cover a=65535, b=255 -> quotient=257, remainder=0; and a=5, b=9 -> quotient=0, remainder=5.
REQ-032 SHALL cover a=1234, b=0 -> done after E0, quotient=16'hFFFF, remainder=0, div_by_zero=1, busy never high; a following request a=10, b=3 gives quotient=3, remainder=1, div_by_zero=0.
REQ-033 SHALL cover start re-pulsed with a=9, b=1 at E5 of a 1000/7 operation -> ignored; result is 142/6 at the original timing.
REQ-034 SHALL cover div_rst at E8 of a 1000/7 operation -> no done pulse, all outputs 0, and a new request 100/10 then yields quotient=10, remainder=0.
REQ-035 SHALL cover back-to-back requests 1000/7 then 200/3 with start held high -> two done pulses 18 edges apart, results 142/6 then 66/2.
